// File: rtl/gnrc_dist_mpram.sv
// gnrc_dist_mpram: one-write / NR-read distributed RAM with byte-lane write
// enables, a post-reset zero-clear sweep, selectable read-during-write
// behaviour and per-port read-valid qualification.
module gnrc_dist_mpram #(
  parameter int unsigned DW         = 32,
  parameter int unsigned DP         = 64,
  parameter int unsigned NR         = 2,
  parameter int unsigned BW         = 8,
  parameter bit          OBUF       = 1'b0,
  parameter bit          RDW_MODE   = 1'b0,
  parameter bit          INIT_SWEEP = 1'b1,
  parameter int unsigned AW         = $clog2(DP)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 busy_o,
  input  logic                 we_i,
  input  logic [DW/BW-1:0]     wbe_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DW-1:0]        wdata_i,
  input  logic [NR-1:0]        re_i,
  input  logic [NR*AW-1:0]     raddr_i,
  output logic [NR*DW-1:0]     rdata_o,
  output logic [NR-1:0]        rvalid_o
);

  localparam int unsigned NB = DW / BW;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          wr_en;
  logic [DW-1:0] mem [DP];

  // DP need not be a power of two, so addresses are range-checked
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DP;
  endfunction

  // Sweep sequencer: clears one entry per cycle after every reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_SWEEP ? SWEEP : IDLE;
      cnt_q   <= '0;
    end else if (state_q == SWEEP) begin
      if (cnt_q == AW'(DP - 1)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + AW'(1);
      end
    end
  end

  assign busy_o = (state_q == SWEEP);
  assign wr_en  = we_i && !busy_o && in_range(waddr_i);

  // Storage: sweep zeroes have priority; user writes update enabled lanes only
  always_ff @(posedge clk_i) begin
    if (busy_o) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wbe_i[k]) mem[waddr_i][k*BW +: BW] <= wdata_i[k*BW +: BW];
      end
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_word;

    assign ra = raddr_i[p*AW +: AW];

    // Read word; in new-data mode a same-address write is overlaid lane by lane
    always_comb begin
      rd_word = in_range(ra) ? mem[ra] : '0;
      if (RDW_MODE && wr_en && (ra == waddr_i)) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (wbe_i[k]) rd_word[k*BW +: BW] = wdata_i[k*BW +: BW];
        end
      end
    end

    if (OBUF) begin : g_reg
      logic [DW-1:0] rdata_q;
      logic          rvalid_q;

      // Capture on an accepted request; data holds otherwise
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= re_i[p] && !busy_o;
          if (re_i[p] && !busy_o) rdata_q <= rd_word;
        end
      end

      assign rdata_o[p*DW +: DW] = rdata_q;
      assign rvalid_o[p]         = rvalid_q;
    end else begin : g_comb
      assign rdata_o[p*DW +: DW] = busy_o ? '0 : rd_word;
      assign rvalid_o[p]         = re_i[p] && !busy_o;
    end
  end

endmodule

// File: tb/tb_gnrc_dist_mpram.sv
// tb_gnrc_dist_mpram: two configurations side by side --
//   u0: DP=64, NR=2, combinational read, old-data read-during-write
//   u1: DP=48, NR=4, registered read, new-data read-during-write
// Expected read results come from bench-side memory models and are queued
// when the read is driven, then popped when the DUT presents the data.
module tb_gnrc_dist_mpram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        we0;
  logic [3:0]  wbe0;
  logic [5:0]  waddr0;
  logic [31:0] wdata0;
  logic [1:0]  re0;
  logic [11:0] raddr0;
  logic [63:0] rdata0;
  logic [1:0]  rvalid0;
  logic        busy0;

  logic         we1;
  logic [3:0]   wbe1;
  logic [5:0]   waddr1;
  logic [31:0]  wdata1;
  logic [3:0]   re1;
  logic [23:0]  raddr1;
  logic [127:0] rdata1;
  logic [3:0]   rvalid1;
  logic         busy1;

  gnrc_dist_mpram #(
    .DW(32), .DP(64), .NR(2), .BW(8),
    .OBUF(1'b0), .RDW_MODE(1'b0), .INIT_SWEEP(1'b1)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .busy_o(busy0),
    .we_i(we0), .wbe_i(wbe0), .waddr_i(waddr0), .wdata_i(wdata0),
    .re_i(re0), .raddr_i(raddr0), .rdata_o(rdata0), .rvalid_o(rvalid0)
  );

  gnrc_dist_mpram #(
    .DW(32), .DP(48), .NR(4), .BW(8),
    .OBUF(1'b1), .RDW_MODE(1'b1), .INIT_SWEEP(1'b1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .busy_o(busy1),
    .we_i(we1), .wbe_i(wbe1), .waddr_i(waddr1), .wdata_i(wdata1),
    .re_i(re1), .raddr_i(raddr1), .rdata_o(rdata1), .rvalid_o(rvalid1)
  );

  typedef struct {
    int unsigned port;
    logic [31:0] data;
    logic        valid;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m0 [64];
  logic [31:0] m1 [48];
  logic [31:0] last1 [4];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    return r;
  endfunction

  task automatic clear_models();
    for (int unsigned i = 0; i < 64; i++) m0[i] = '0;
    for (int unsigned i = 0; i < 48; i++) m1[i] = '0;
    for (int unsigned i = 0; i < 4; i++) last1[i] = '0;
  endtask

  // One clock with inputs already driven at the preceding falling edge
  task automatic cycle();
    exp_t        e;
    logic [5:0]  ra;
    logic [31:0] w;
    for (int unsigned p = 0; p < 2; p++) begin
      ra      = raddr0[p*6 +: 6];
      e.port  = p;
      e.data  = m0[ra];
      e.valid = re0[p];
      q0.push_back(e);
    end
    for (int unsigned p = 0; p < 4; p++) begin
      ra = raddr1[p*6 +: 6];
      if (re1[p]) begin
        w = (int'(ra) < 48) ? m1[ra] : '0;
        if (we1 && int'(waddr1) < 48 && waddr1 == ra) w = merge(w, wdata1, wbe1);
        last1[p] = w;
      end
      e.port  = p;
      e.data  = last1[p];
      e.valid = re1[p];
      q1.push_back(e);
    end
    if (we0) m0[waddr0] = merge(m0[waddr0], wdata0, wbe0);
    if (we1 && int'(waddr1) < 48) m1[waddr1] = merge(m1[waddr1], wdata1, wbe1);
    #1;
    while (q0.size() > 0) begin
      e = q0.pop_front();
      chk($sformatf("u0_p%0d_rdata", e.port), rdata0[e.port*32 +: 32], e.data);
      chk($sformatf("u0_p%0d_rvalid", e.port), 32'(rvalid0[e.port]), 32'(e.valid));
    end
    @(posedge clk);
    #1;
    while (q1.size() > 0) begin
      e = q1.pop_front();
      chk($sformatf("u1_p%0d_rdata", e.port), rdata1[e.port*32 +: 32], e.data);
      chk($sformatf("u1_p%0d_rvalid", e.port), 32'(rvalid1[e.port]), 32'(e.valid));
    end
    @(negedge clk);
  endtask

  // Count busy cycles (bounded); reads are requested and a write to an
  // already-cleared entry is attempted at sweep cycle 30, both must be ignored
  task automatic sweep_wait(input int unsigned stop_at, output int unsigned n0,
                            output int unsigned n1);
    n0 = 0;
    n1 = 0;
    raddr0 = {6'd5, 6'd5};
    raddr1 = {4{6'd5}};
    wbe0 = '1; waddr0 = 6'd5; wdata0 = 32'hDEADBEEF;
    wbe1 = '1; waddr1 = 6'd5; wdata1 = 32'hDEADBEEF;
    for (int unsigned i = 0; i < 200; i++) begin
      if (i == stop_at || (!busy0 && !busy1)) break;
      re0 = {2{busy0}};
      re1 = {4{busy1}};
      we0 = (i == 30);
      we1 = (i == 30);
      #1;
      if (busy0) begin
        n0++;
        chk("busy_u0_rvalid", 32'(rvalid0), 32'd0);
        chk("busy_u0_rdata0", rdata0[31:0], 32'd0);
        chk("busy_u0_rdata1", rdata0[63:32], 32'd0);
      end
      if (busy1) begin
        n1++;
        chk("busy_u1_rvalid", 32'(rvalid1), 32'd0);
      end
      @(negedge clk);
    end
    we0 = 1'b0; we1 = 1'b0; re0 = '0; re1 = '0;
  endtask

  task automatic read_all();
    for (int unsigned i = 0; i < 64; i++) begin
      re0    = '1;
      raddr0 = {6'(63 - i), 6'(i)};
      re1    = '1;
      raddr1 = {6'((i + 36) % 48), 6'((i + 24) % 48), 6'((i + 12) % 48), 6'(i % 48)};
      cycle();
    end
    re0 = '0; re1 = '0;
  endtask

  initial begin
    int unsigned n0, n1;
    rst_n = 1'b1;
    we0 = 0; wbe0 = 0; waddr0 = 0; wdata0 = 0; re0 = '1; raddr0 = 0;
    we1 = 0; wbe1 = 0; waddr1 = 0; wdata1 = 0; re1 = '1; raddr1 = 0;
    clear_models();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy_u0", 32'(busy0), 32'd1);
    chk("rst_busy_u1", 32'(busy1), 32'd1);
    chk("rst_rvalid_u0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid_u1", 32'(rvalid1), 32'd0);
    chk("rst_rdata_u1_p0", rdata1[31:0], 32'd0);
    chk("rst_rdata_u1_p3", rdata1[127:96], 32'd0);
    re0 = '0; re1 = '0;
    rst_n = 1'b1;
    sweep_wait(1000, n0, n1);
    chk("sweep_len_u0", n0, 32'd64);
    chk("sweep_len_u1", n1, 32'd48);

    // Fill with garbage, then restart the sweep mid-way
    for (int unsigned i = 0; i < 64; i++) begin
      we0 = 1'b1; wbe0 = '1; waddr0 = 6'(i); wdata0 = 32'hC0DE0000 | i;
      we1 = (i < 48); wbe1 = '1; waddr1 = 6'(i); wdata1 = 32'hBAD00000 | i;
      cycle();
    end
    we0 = 1'b0; we1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_wait(20, n0, n1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_wait(1000, n0, n1);
    chk("resweep_len_u0", n0, 32'd64);
    chk("resweep_len_u1", n1, 32'd48);
    clear_models();
    read_all();

    // Full write then single-lane partial write
    we0 = 1; wbe0 = 4'hF; waddr0 = 6'd5; wdata0 = 32'hDEADBEEF;
    we1 = 1; wbe1 = 4'hF; waddr1 = 6'd5; wdata1 = 32'hDEADBEEF;
    cycle();
    wbe0 = 4'b0010; wdata0 = 32'h0000AA00;
    wbe1 = 4'b0010; wdata1 = 32'h0000AA00;
    cycle();
    we0 = 0; we1 = 0;
    re0 = 2'b01; raddr0 = {6'd5, 6'd5};
    re1 = 4'b0001; raddr1 = {4{6'd5}};
    cycle();
    re0 = '0; re1 = '0;
    cycle();

    // Read-during-write, full word then lane 0 only
    we0 = 1; wbe0 = 4'hF; waddr0 = 6'd9; wdata0 = 32'h12345678;
    we1 = 1; wbe1 = 4'hF; waddr1 = 6'd9; wdata1 = 32'h12345678;
    re0 = 2'b01; raddr0 = {6'd0, 6'd9};
    re1 = 4'b0001; raddr1 = {18'd0, 6'd9};
    cycle();
    we0 = 0; we1 = 0;
    cycle();
    we0 = 1; wbe0 = 4'b0001; waddr0 = 6'd10;
    we1 = 1; wbe1 = 4'b0001; waddr1 = 6'd10;
    raddr0 = {6'd0, 6'd10};
    raddr1 = {18'd0, 6'd10};
    cycle();
    we0 = 0; we1 = 0;
    cycle();

    // Empty byte mask on u0, out-of-range write and read on u1
    we0 = 1; wbe0 = 4'b0000; waddr0 = 6'd5; wdata0 = 32'hFFFFFFFF;
    we1 = 1; wbe1 = 4'hF; waddr1 = 6'd50; wdata1 = 32'hFFFFFFFF;
    re0 = '0; re1 = '0;
    cycle();
    we0 = 0; we1 = 0;
    re1 = 4'b0001; raddr1 = {18'd0, 6'd50};
    cycle();

    // All ports on one address, port 2 idle on u1
    we0 = 1; wbe0 = 4'hF; waddr0 = 6'd3; wdata0 = 32'hA5A5A5A5;
    we1 = 1; wbe1 = 4'hF; waddr1 = 6'd3; wdata1 = 32'hA5A5A5A5;
    re1 = '0;
    cycle();
    we0 = 0; we1 = 0;
    re0 = 2'b11; raddr0 = {2{6'd3}};
    re1 = 4'b1011; raddr1 = {4{6'd3}};
    cycle();
    re0 = '0; re1 = '0;

    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnrc_dist_mpram.md
Name: gnrc_dist_mpram

Overview:
Parametrised multi-read-port distributed RAM: one write port with byte enables and NR independent read ports, synthesisable as LUT RAM. Adds a post-reset zero-clear sweep engine, selectable read-during-write semantics, and per-port read-valid qualification. Used as register files, small lookup tables and descriptor stores in the generic library.

Parameters:
DW, 32, data width in bits; must be a multiple of BW.
DP, 64, depth in entries; >=2, need not be a power of 2.
NR, 2, number of read ports; >=1.
BW, 8, byte-enable granularity in bits; NB = DW/BW lanes.
OBUF, 0, 1 = registered read data (1-cycle latency); 0 = combinational read.
RDW_MODE, 0, read-during-write to the same address: 0 = old data, 1 = new (byte-merged) data.
INIT_SWEEP, 1, 1 = clear all entries to zero after every reset; 0 = contents untouched by reset.
AW, $clog2(DP), address width; derived, do not override.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
busy_o  output  1  high while the init sweep runs; all port activity is ignored
we_i  input  1  write request
wbe_i  input  NB  byte-lane write enables, lane k = wdata_i[k*BW +: BW]
waddr_i  input  AW  write address
wdata_i  input  DW  write data
re_i  input  NR  per-port read request
raddr_i  input  NR*AW  read addresses, port p = [p*AW +: AW]
rdata_o  output  NR*DW  read data, port p = [p*DW +: DW]
rvalid_o  output  NR  per-port read data valid

Behaviour:
- Reset (rst_ni low, async): busy_o = INIT_SWEEP; sweep counter = 0; rvalid_o = 0; registered rdata_o = 0 when OBUF=1. RAM array has no reset.
- Sweep FSM, states IDLE/SWEEP. Entry: SWEEP after reset release if INIT_SWEEP=1, else IDLE. In SWEEP, write zero to entry cnt each cycle, cnt++. After the write to DP-1, go to IDLE. busy_o is high for exactly DP cycles after reset release.
- Reset asserted mid-sweep: restart from entry 0 after release.
- While busy_o=1: we_i ignored, rvalid_o=0, rdata_o=0.
- Write: when we_i & ~busy_o & waddr_i<DP, lanes with wbe_i[k]=1 update at the clock edge. wbe_i=0 is a no-op. waddr_i>=DP drops the write silently.
- Read, OBUF=0: rdata_o[p] = ram[raddr_i[p]] combinationally; rvalid_o[p] = re_i[p] & ~busy_o, combinational.
- Read, OBUF=1: on an edge with re_i[p] & ~busy_o, capture data; rvalid_o[p]=1 in the next cycle. Otherwise rvalid_o[p]=0 and rdata_o[p] holds its last value.
- raddr_i[p]>=DP: rdata 0, rvalid still asserted.
- Read-during-write, same address, same cycle, RDW_MODE=1: data = old word with enabled lanes replaced by wdata_i. Applies to the combinational path (OBUF=0) and the captured value (OBUF=1).
- Read-during-write, RDW_MODE=0: old word is returned. For OBUF=0 the new word is visible from the next cycle.
- All NR ports may read the same address in the same cycle; each gets an identical result.
- No back-pressure; the write is single-port, so there are no write conflicts.

Test Plan:
- DP=64, INIT_SWEEP=1: release reset after preloading garbage via backdoor. busy_o high for exactly 64 cycles, then all 64 entries read 0 on both ports; rvalid_o=0 throughout busy.
- Write 0xDEADBEEF to addr 5 with wbe=4'hF, then wbe=4'b0010 with data 0x0000AA00 -> read addr 5 = 0xDEADAAEF. With OBUF=1, rvalid_o[0] appears one cycle after re_i[0].
- Same-cycle write 0x12345678 and read of addr 9, old value 0x0: RDW_MODE=0 returns 0x0; RDW_MODE=1 returns 0x12345678; repeat with wbe=4'b0001 -> 0x00000078.
- DP=48: write 0xFFFFFFFF to addr 50 -> dropped, no entry modified; read addr 50 -> 0 with rvalid_o=1.
- Assert rst_ni at sweep cycle 20, release -> sweep restarts with busy_o high for 64 full cycles; a write attempted during busy is lost.
- NR=4, all ports read addr 3 (=0xA5A5A5A5) while port 2 idles (re_i=4'b1011) -> ports 0, 1 and 3 return 0xA5A5A5A5 with valid; rvalid_o[2]=0.
